// File: rtl/spi_config_arbiter.sv
// Round-robin arbiter sharing one quick_spi master between on-chip requesters.
// Each grant runs one 16-bit transaction with a timeout guard and a post-transaction gap.
module spi_config_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_slave,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_operation,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [7:0]              rsp_data,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic                    spi_enable,
  output logic                    spi_start_transaction,
  output logic [1:0]              spi_slave,
  output logic [15:0]             spi_outgoing_data,
  output logic                    spi_operation,
  input  logic [7:0]              spi_incoming_data,
  input  logic                    spi_end_of_transaction,
  output logic [2:0]              fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESPOND = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t           state;
  logic [2:0]       rr_ptr;
  logic [CNT_W-1:0] to_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             found;
  logic [2:0]       win;
  logic [3:0]       idx;
  logic [1:0]       sel_slave;
  logic [15:0]      sel_data;
  logic             sel_op;

  // Rotating priority search: offset i from rr_ptr, wrapped modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && idx == 4'(j)) begin
          found = 1'b1;
          win   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    sel_slave = '0;
    sel_data  = '0;
    sel_op    = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == 3'(j)) begin
        sel_slave = req_slave[2*j +: 2];
        sel_data  = req_data[16*j +: 16];
        sel_op    = req_operation[j];
      end
    end
  end

  // Handshake: a request is accepted on the edge where req_valid[i] & req_ready[i];
  // req_ready is a combinational one-hot strobe, only ever high in IDLE.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = reset_n && (state == S_IDLE) && found && (win == 3'(j));
    end
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                 <= S_IDLE;
      rr_ptr                <= '0;
      grant_id              <= '0;
      to_cnt                <= '0;
      gap_cnt               <= '0;
      rsp_valid             <= '0;
      rsp_data              <= '0;
      rsp_timeout           <= 1'b0;
      spi_enable            <= 1'b0;
      spi_start_transaction <= 1'b0;
      spi_slave             <= '0;
      spi_outgoing_data     <= '0;
      spi_operation         <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id              <= win;
            spi_slave             <= sel_slave;
            spi_outgoing_data     <= sel_data;
            spi_operation         <= sel_op;
            spi_enable            <= 1'b1;
            spi_start_transaction <= 1'b1;
            state                 <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // End of transaction takes priority over a timeout in the same cycle.
          if (spi_end_of_transaction || to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data    <= spi_end_of_transaction ? spi_incoming_data : 8'h00;
            rsp_timeout <= ~spi_end_of_transaction;
            for (int j = 0; j < NUM_REQ; j++) begin
              rsp_valid[j] <= (grant_id == 3'(j));
            end
            spi_enable            <= 1'b0;
            spi_start_transaction <= 1'b0;
            state                 <= S_RESPOND;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        S_RESPOND: begin
          rr_ptr  <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
          gap_cnt <= '0;
          state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_arbiter.sv
// Directed plus randomized bench for spi_config_arbiter against a transaction-level
// model of round-robin grants, response latency, timeout and gap behaviour.
module tb_spi_config_arbiter;

  localparam int NR  = 3;
  localparam int TO  = 100;
  localparam int GAP = 2;

  logic                 clk;
  logic                 reset_n;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [2*NR-1:0]      req_slave;
  logic [16*NR-1:0]     req_data;
  logic [NR-1:0]        req_operation;
  logic [NR-1:0]        rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_timeout;
  logic                 busy;
  logic [2:0]           grant_id;
  logic                 spi_enable;
  logic                 spi_start_transaction;
  logic [1:0]           spi_slave;
  logic [15:0]          spi_outgoing_data;
  logic                 spi_operation;
  logic [7:0]           spi_incoming_data;
  logic                 spi_end_of_transaction;
  logic [2:0]           fsm_state;

  spi_config_arbiter #(
    .NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave),
    .req_data(req_data), .req_operation(req_operation),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy), .grant_id(grant_id),
    .spi_enable(spi_enable), .spi_start_transaction(spi_start_transaction),
    .spi_slave(spi_slave), .spi_outgoing_data(spi_outgoing_data),
    .spi_operation(spi_operation), .spi_incoming_data(spi_incoming_data),
    .spi_end_of_transaction(spi_end_of_transaction), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Scoreboard and reference model state
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  int          m_ptr;
  logic        m_valid[NR];
  logic [1:0]  m_slave[NR];
  logic [15:0] m_data[NR];
  logic        m_op[NR];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // Next owner: first pending requester at or after the pointer, wrapping.
  function automatic int pick();
    int r;
    int k;
    r = -1;
    for (int j = 0; j < NR; j++) begin
      k = (m_ptr + j) % NR;
      if (r < 0 && m_valid[k]) r = k;
    end
    return r;
  endfunction

  // Driver tasks
  task automatic post(input int i, input logic [1:0] s, input logic [15:0] d, input logic op);
    m_valid[i] = 1'b1;
    m_slave[i] = s;
    m_data[i]  = d;
    m_op[i]    = op;
    req_valid[i]          = 1'b1;
    req_slave[2*i +: 2]   = s;
    req_data[16*i +: 16]  = d;
    req_operation[i]      = op;
  endtask

  task automatic post_rand(input int i);
    post(i, 2'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Drop the request and scribble over its fields; the transaction in flight must not care.
  task automatic drop(input int i);
    m_valid[i]           = 1'b0;
    req_valid[i]         = 1'b0;
    req_slave[2*i +: 2]  = 2'($urandom);
    req_data[16*i +: 16] = 16'($urandom);
    req_operation[i]     = ~req_operation[i];
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, 64'({rsp_valid, rsp_data, rsp_timeout, busy, grant_id, spi_enable,
                    spi_start_transaction, spi_slave, spi_outgoing_data, spi_operation}), 64'(0));
  endtask

  // Master model: pulse end_of_transaction so it is sampled d+1 edges after accept.
  task automatic respond_loop(input int d, input logic use_eot, input logic [7:0] din,
                              input logic [15:0] ed, output int n, output logic held);
    int eot_edge;
    eot_edge = use_eot ? d + 1 : -1;
    n        = 0;
    held     = 1'b1;
    for (int e = 1; e <= TO + 8; e++) begin
      spi_end_of_transaction = (e == eot_edge);
      spi_incoming_data      = din;
      step();
      spi_end_of_transaction = 1'b0;
      if (rsp_valid != '0) begin
        n = e;
        break;
      end
      held = held & spi_enable & spi_start_transaction & (spi_outgoing_data == ed);
    end
  endtask

  task automatic through_gap(input logic stray);
    for (int g = 0; g < GAP; g++) begin
      spi_end_of_transaction = (g == 0) ? stray : 1'b0;
      spi_incoming_data      = 8'hEE;
      step();
      spi_end_of_transaction = 1'b0;
      check("gap_quiet", 64'({req_ready, rsp_valid, busy}), 64'(1));
    end
    step();
  endtask

  task automatic run_one(input int w, input int d, input logic use_eot,
                         input logic [7:0] din, input logic stray);
    int          n;
    logic        held;
    logic [1:0]  es;
    logic [15:0] ed;
    logic        eo;
    logic [11:0] e;
    es = m_slave[w];
    ed = m_data[w];
    eo = m_op[w];
    #1;
    check("ready_onehot", 64'(req_ready), 64'(onehot(w)));
    exp_q.push_back({3'(w), ~use_eot, use_eot ? din : 8'h00});
    step();
    drop(w);
    check("issue", 64'({spi_enable, spi_start_transaction, spi_slave, spi_outgoing_data,
                        spi_operation, grant_id, busy}),
          64'({1'b1, 1'b1, es, ed, eo, 3'(w), 1'b1}));
    respond_loop(d, use_eot, din, ed, n, held);
    check("wait_held", 64'(held), 64'(1));
    check("latency", 64'(n), 64'(use_eot ? d + 1 : TO + 1));
    check("rsp_valid", 64'(rsp_valid), 64'(onehot(w)));
    check("spi_released", 64'({spi_enable, spi_start_transaction}), 64'(0));
    e = exp_q.pop_front();
    check("rsp_fields", 64'({grant_id, rsp_timeout, rsp_data}), 64'(e));
    m_ptr = (w + 1) % NR;
    through_gap(stray);
  endtask

  initial begin
    logic any;
    int   w;
    int   mode;
    reset_n                = 1'b0;
    req_valid              = '0;
    req_slave              = '0;
    req_data               = '0;
    req_operation          = '0;
    spi_incoming_data      = '0;
    spi_end_of_transaction = 1'b0;
    m_ptr                  = 0;
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_slave[i] = '0;
      m_data[i]  = '0;
      m_op[i]    = 1'b0;
    end

    // Reset values, with requests visible but held off by reset
    req_valid = '1;
    step();
    step();
    check("reset_ready", 64'(req_ready), 64'(0));
    check_reset_outs("reset_outs");
    req_valid = '0;
    reset_n   = 1'b1;
    step();

    // Single write: end_of_transaction 40 cycles after start, stray pulse in gap
    post(0, 2'd0, 16'h3B05, 1'b1);
    run_one(0, 40, 1'b1, 8'h5C, 1'b1);

    // Read capture from requester 2
    post(2, 2'd3, 16'h1234, 1'b0);
    run_one(2, 5, 1'b1, 8'hA5, 1'b0);

    // Stray end_of_transaction in IDLE; response fields must hold
    spi_end_of_transaction = 1'b1;
    spi_incoming_data      = 8'hFF;
    step();
    spi_end_of_transaction = 1'b0;
    step();
    check("idle_stray", 64'({rsp_valid, busy, rsp_timeout, rsp_data}), 64'(8'hA5));

    // Timeout, then pointer advance and normal service
    post(1, 2'd1, 16'hBEEF, 1'b1);
    run_one(1, 0, 1'b0, 8'h00, 1'b0);
    post(0, 2'd2, 16'h0F0F, 1'b1);
    post(2, 2'd1, 16'hF0F0, 1'b0);
    run_one(2, 3, 1'b1, 8'h3C, 1'b0);
    run_one(0, 7, 1'b1, 8'hC3, 1'b0);

    // end_of_transaction on the very cycle the timeout would fire
    post(1, 2'd2, 16'h5555, 1'b0);
    run_one(1, TO, 1'b1, 8'h77, 1'b0);

    // Reset mid-WAIT: no response, everything back to reset values
    post(2, 2'd1, 16'hCAFE, 1'b1);
    #1;
    check("ready_abort", 64'(req_ready), 64'(onehot(pick())));
    step();
    drop(2);
    repeat (3) step();
    check("abort_in_wait", 64'({busy, spi_enable, rsp_valid}), 64'({1'b1, 1'b1, {NR{1'b0}}}));
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) post_rand(i);
    m_ptr = 0;
    #1;
    check("abort_ready_gated", 64'(req_ready), 64'(0));
    step();
    check_reset_outs("abort_reset_outs");
    reset_n = 1'b1;

    // Fairness: all three held valid from reset
    for (int k = 0; k < 2 * NR; k++) begin
      run_one(k % NR, $urandom_range(1, 6), 1'b1, 8'($urandom), 1'b0);
      post_rand(k % NR);
    end

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      any = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!m_valid[i] && $urandom_range(0, 1) == 1) post_rand(i);
        any = any | m_valid[i];
      end
      if (!any) post_rand($urandom_range(0, NR - 1));
      w    = pick();
      mode = $urandom_range(0, 9);
      if (mode == 0)      run_one(w, 0, 1'b0, 8'($urandom), 1'($urandom));
      else if (mode == 1) run_one(w, TO, 1'b1, 8'($urandom), 1'($urandom));
      else                run_one(w, $urandom_range(1, 12), 1'b1, 8'($urandom), 1'($urandom));
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_config_arbiter.md
# spi_config_arbiter

Shares one SPI master (the quick_spi engine) between several on-chip requesters: the power-up sensor configurator, runtime ADC-gain updater and register readback. It sits between the requesters and the master's enable/start/end_of_transaction interface. Each request is a single 16-bit SPI transaction. Grants are round-robin, with a timeout guard and an inter-transaction gap.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- TIMEOUT_CYCLES, 4096, max clk cycles spent waiting for end_of_transaction
- GAP_CYCLES, 2, idle cycles between transactions; 0 allowed
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_slave  in  2*NUM_REQ  slave index per requester; requester i owns bits [2i+1:2i]
- req_data  in  16*NUM_REQ  outgoing word per requester; requester i owns bits [16i+15:16i]
- req_operation  in  NUM_REQ  1 = write, 0 = read, per requester
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_data  out  8  captured incoming_data, shared by all requesters
- rsp_timeout  out  1  valid with rsp_valid; 1 = transaction aborted
- busy  out  1  high in every state except IDLE
- grant_id  out  3  index of the current or last owner
- spi_enable, spi_start_transaction  out  1  drive the master
- spi_slave  out  2;  spi_outgoing_data  out  16;  spi_operation  out  1
- spi_incoming_data  in  8;  spi_end_of_transaction  in  1

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND, GAP.
- IDLE: search req_valid starting at pointer rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready[winner] is asserted combinationally in the same cycle. Handshake is req_valid & req_ready.
  - On accept: latch slave, data, operation and grant_id, then go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE (1 cycle): assert registered spi_enable=1, spi_start_transaction=1 and the latched slave, data and operation. Go to WAIT.
- WAIT: hold all spi_* outputs and increment the timeout counter each cycle.
  - spi_end_of_transaction=1: capture spi_incoming_data into rsp_data (both reads and writes). Go to RESPOND with rsp_timeout=0.
  - Counter reaches TIMEOUT_CYCLES first: rsp_data=0, rsp_timeout=1, go to RESPOND.
  - end_of_transaction and timeout in the same cycle: end_of_transaction wins.
- RESPOND (1 cycle):
  - rsp_valid[grant_id]=1.
  - spi_start_transaction=0 and spi_enable=0.
  - rr_ptr = (grant_id+1) mod NUM_REQ.
  - Next state is GAP, or IDLE when GAP_CYCLES=0.
- GAP: stay GAP_CYCLES cycles, then IDLE. New requests are not accepted in GAP.
- spi_end_of_transaction is ignored outside WAIT.
- Changes to req_* inputs after accept have no effect on the transaction in flight.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0, grant_id=0, rr_ptr=0, all spi_* outputs 0, state IDLE.
- Reset asserted mid-transaction forces reset values at the next edge. No response is issued for the aborted request.

## Timing
- Accept edge is cycle 0; spi_start_transaction rises at cycle 1.
- If end_of_transaction is sampled at cycle k, rsp_valid is high in cycle k+1 and spi_enable is low from cycle k+1.
- Next accept is no earlier than cycle k+2+GAP_CYCLES.
- Timeout response: rsp_valid occurs TIMEOUT_CYCLES+2 cycles after accept.
- A single requester holding req_valid is served every transaction time + GAP_CYCLES + 3 cycles.
- rsp_data and rsp_timeout hold their values until the next RESPOND.

## Test plan
- Single write: req 0, slave 0, data 0x3B05, op=1; model the master with end_of_transaction 40 cycles after start → spi_outgoing_data=0x3B05 and spi_slave=0 from cycle 1; rsp_valid[0] at cycle 42 with rsp_timeout=0.
- Fairness: all three requesters held valid from reset → grant order 0,1,2,0,1,2; no requester is granted twice before the others.
- Read capture: req 2, op=0, master returns 0xA5 with end_of_transaction → rsp_data=0xA5, rsp_valid=3'b100.
- Timeout: master never ends → rsp_timeout=1 and rsp_data=0 at cycle TIMEOUT_CYCLES+2; rr_ptr advances; the next request is served normally.
- Reset mid-WAIT: reset_n low for one cycle → all outputs at reset values, no rsp_valid pulse; a subsequent request from requester 0 completes.
- Stray end_of_transaction pulse in IDLE and GAP → ignored; no rsp_valid, state unchanged.
